apb_req_arbiter: RTL and testbench



---
 rtl/apb_req_arbiter.sv | 144 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter that shares one APB bus among NREQ
// on-chip requesters. It runs the APB SETUP/ACCESS sequence itself with
// registered psel/penable/pwrite/paddr/pwdata and returns read data plus a
// one-cycle completion pulse to the owning requester.
//
// Optional feature: define APB3_WAIT_EN to add pready/pslverr inputs and the
// req_err output. When it is undefined, every ACCESS phase lasts one cycle.
module apb_req_arbiter #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       pclk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            req_gnt,
  output logic [NREQ-1:0]            req_ack,
  output logic [DATA_WIDTH-1:0]      req_rdata,
`ifdef APB3_WAIT_EN
  input  logic                       pready,
  input  logic                       pslverr,
  output logic                       req_err,
`endif
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [ADDR_WIDTH-1:0]      paddr,
  output logic [DATA_WIDTH-1:0]      pwdata,
  input  logic [DATA_WIDTH-1:0]      prdata
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      rr_nxt;
  logic                  pready_int;
  logic                  completion;
  logic [NREQ-1:0]       cand;
  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  logic [NREQ-1:0]       win_onehot;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  win_write;

`ifdef APB3_WAIT_EN
  assign pready_int = pready;
  assign req_err    = completion & pslverr;
`else
  assign pready_int = 1'b1;
`endif

  assign completion = (state == ST_ACCESS) & pready_int;
  assign req_ack    = completion ? req_gnt : '0;
  assign req_rdata  = prdata;

  // Candidate set: any requester in IDLE; everyone but the finishing owner at completion.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cand = '0;
    if (state == ST_IDLE) begin
      cand = req;
    end else if (completion) begin
      cand = req & ~req_gnt;
    end
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx        = 0;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_addr   = '0;
    win_wdata  = '0;
    win_write  = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && cand[idx]) begin
        win_found       = 1'b1;
        win_idx         = PTR_W'(idx);
        win_onehot[idx] = 1'b1;
        win_addr        = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata       = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
        win_write       = req_write[idx];
      end
    end
  end

  assign rr_nxt = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;

  // Next-state logic for the IDLE -> SETUP -> ACCESS sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (win_found) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (completion) state_nxt = win_found ? ST_SETUP : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State, registered APB outputs, and the transfer latched on each grant.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      req_gnt <= '0;
      rr_ptr  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking would let later lines see half-updated state.
      state   <= state_nxt;
      psel    <= (state_nxt != ST_IDLE);
      penable <= (state_nxt == ST_ACCESS);
      if (win_found) begin
        req_gnt <= win_onehot;
        paddr   <= win_addr;
        pwdata  <= win_wdata;
        pwrite  <= win_write;
        rr_ptr  <= rr_nxt;
      end else if (state_nxt == ST_IDLE) begin
        req_gnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed scenarios followed by randomized traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_apb_req_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic                 pclk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req, req_write, req_gnt, req_ack;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [DW-1:0]        req_rdata, pwdata, prdata;
  logic [AW-1:0]        paddr;
  logic                 psel, penable, pwrite;
`ifdef APB3_WAIT_EN
  logic                 pready, pslverr, req_err;
`endif

  int total = 0;
  int bad   = 0;

  apb_req_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .pclk      (pclk),
    .reset     (reset),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_gnt   (req_gnt),
    .req_ack   (req_ack),
    .req_rdata (req_rdata),
`ifdef APB3_WAIT_EN
    .pready    (pready),
    .pslverr   (pslverr),
    .req_err   (req_err),
`endif
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Wait for the falling edge, then compare the bus control outputs.
  task automatic expect_bus(input string tag, input logic e_psel, input logic e_pen,
                            input logic [NREQ-1:0] e_gnt, input logic [NREQ-1:0] e_ack);
    @(negedge pclk);
    check({tag, ".psel"},    psel,    e_psel);
    check({tag, ".penable"}, penable, e_pen);
    check({tag, ".gnt"},     req_gnt, e_gnt);
    check({tag, ".ack"},     req_ack, e_ack);
  endtask

  // Round-robin pick from the rules: first set bit at or after ptr, wrapping.
  function automatic int pick(input logic [NREQ-1:0] c, input int ptr);
    for (int off = 0; off < NREQ; off++) begin
      if (c[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    end
    return -1;
  endfunction

  // Reference model: phase 0 = no transfer, 1 = setup cycle, 2 = access cycle.
  int              m_phase, m_owner, m_rr;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_write;

  task automatic m_grant(input int w);
    m_owner = w;
    m_phase = 1;
    m_addr  = req_addr[w*AW +: AW];
    m_wdata = req_wdata[w*DW +: DW];
    m_write = req_write[w];
    m_rr    = (w + 1) % NREQ;
  endtask

  initial begin
    logic [NREQ-1:0] e_gnt, e_ack, n_req, cur_req;
    logic            ready;
    int              w;

    reset = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0; prdata = '0;
`ifdef APB3_WAIT_EN
    pready = 1'b1; pslverr = 1'b0;
`endif
    step();
    // Reset state
    expect_bus("reset", 1'b0, 1'b0, '0, '0);
    check("reset.paddr", paddr, '0);
    check("reset.pwdata", pwdata, '0);
    check("reset.pwrite", pwrite, 1'b0);
    reset = 1'b0;

    // Single write from requester 0
    step();
    set_req(0, 1'b1, 32'h10, 32'hA5); req = 4'b0001;
    expect_bus("wr_c0", 1'b0, 1'b0, '0, '0);
    step();
    expect_bus("wr_setup", 1'b1, 1'b0, 4'b0001, '0);
    check("wr_setup.paddr", paddr, 32'h10);
    check("wr_setup.pwdata", pwdata, 32'hA5);
    check("wr_setup.pwrite", pwrite, 1'b1);
    step();
    expect_bus("wr_access", 1'b1, 1'b1, 4'b0001, 4'b0001);
    check("wr_access.paddr", paddr, 32'h10);
    step(); req = '0;
    expect_bus("wr_idle", 1'b0, 1'b0, '0, '0);

    // Read from requester 2
    set_req(2, 1'b0, 32'h24, 32'h0); req = 4'b0100; prdata = 32'hDEADBEEF;
    step();
    expect_bus("rd_setup", 1'b1, 1'b0, 4'b0100, '0);
    check("rd_setup.paddr", paddr, 32'h24);
    check("rd_setup.pwrite", pwrite, 1'b0);
    step();
    expect_bus("rd_access", 1'b1, 1'b1, 4'b0100, 4'b0100);
    check("rd_access.rdata", req_rdata, 32'hDEADBEEF);
    step(); req = '0;
    expect_bus("rd_idle", 1'b0, 1'b0, '0, '0);

    // Contention after a fresh reset: grants 0,1,2,3 back to back
    reset = 1'b1; #2; reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, i[0], 32'h100 + 32'(i * 4), 32'h1000 + 32'(i));
    req = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      step();
      if (k > 0) req[k-1] = 1'b0;
      expect_bus($sformatf("cont%0d_setup", k), 1'b1, 1'b0, NREQ'(1 << k), '0);
      check($sformatf("cont%0d.paddr", k), paddr, 32'h100 + 32'(k * 4));
      step();
      expect_bus($sformatf("cont%0d_access", k), 1'b1, 1'b1, NREQ'(1 << k), NREQ'(1 << k));
    end
    step(); req[NREQ-1] = 1'b0;
    expect_bus("cont_idle", 1'b0, 1'b0, '0, '0);

    // Same requester twice: one IDLE cycle between ack and the next SETUP
    set_req(1, 1'b1, 32'h44, 32'h55); req = 4'b0010;
    step();
    expect_bus("rep_setup1", 1'b1, 1'b0, 4'b0010, '0);
    step();
    expect_bus("rep_access1", 1'b1, 1'b1, 4'b0010, 4'b0010);
    step();
    expect_bus("rep_idle", 1'b0, 1'b0, '0, '0);
    step();
    expect_bus("rep_setup2", 1'b1, 1'b0, 4'b0010, '0);
    step();
    expect_bus("rep_access2", 1'b1, 1'b1, 4'b0010, 4'b0010);
    step(); req = '0;
    expect_bus("rep_end", 1'b0, 1'b0, '0, '0);

    // Reset asserted in ACCESS aborts the transfer immediately
    set_req(0, 1'b1, 32'h60, 32'h61); req = 4'b0001;
    step();
    step();
    #2; reset = 1'b1; #1;
    check("rst_mid.psel", psel, 1'b0);
    check("rst_mid.penable", penable, 1'b0);
    check("rst_mid.gnt", req_gnt, '0);
    check("rst_mid.ack", req_ack, '0);
    set_req(3, 1'b0, 32'h70, 32'h0); req = 4'b1000;
    @(negedge pclk); reset = 1'b0;
    step();
    expect_bus("rst_after_setup", 1'b1, 1'b0, 4'b1000, '0);
    check("rst_after.paddr", paddr, 32'h70);
    step();
    expect_bus("rst_after_access", 1'b1, 1'b1, 4'b1000, 4'b1000);
    step(); req = '0;

`ifdef APB3_WAIT_EN
    // Wait states: three cycles of pready=0, then completion with an error
    set_req(0, 1'b1, 32'h30, 32'h31); req = 4'b0001;
    step(); pready = 1'b0;
    expect_bus("ws_setup", 1'b1, 1'b0, 4'b0001, '0);
    for (int c = 0; c < 3; c++) begin
      step();
      expect_bus($sformatf("ws_wait%0d", c), 1'b1, 1'b1, 4'b0001, '0);
      check($sformatf("ws_wait%0d.paddr", c), paddr, 32'h30);
      check($sformatf("ws_wait%0d.err", c), req_err, 1'b0);
    end
    step(); pready = 1'b1; pslverr = 1'b1;
    expect_bus("ws_done", 1'b1, 1'b1, 4'b0001, 4'b0001);
    check("ws_done.err", req_err, 1'b1);
    step(); req = '0; pslverr = 1'b0;
`endif

    // Randomized traffic against the reference model
    reset = 1'b1; #1; reset = 1'b0;
    m_phase = 0; m_owner = -1; m_rr = 0; m_addr = '0; m_wdata = '0; m_write = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge pclk);
      ready = 1'b1;
`ifdef APB3_WAIT_EN
      ready = pready;
`endif
      e_gnt = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
      e_ack = (m_phase == 2 && ready) ? e_gnt : '0;
      check("rnd.psel",    psel,    m_phase != 0);
      check("rnd.penable", penable, m_phase == 2);
      check("rnd.gnt",     req_gnt, e_gnt);
      check("rnd.ack",     req_ack, e_ack);
      check("rnd.paddr",   paddr,   m_addr);
      check("rnd.pwdata",  pwdata,  m_wdata);
      check("rnd.pwrite",  pwrite,  m_write);
      if (e_ack != '0) check("rnd.rdata", req_rdata, prdata);
`ifdef APB3_WAIT_EN
      check("rnd.err", req_err, (m_phase == 2) && pready && pslverr);
`endif
      // Advance the model using the inputs seen at the coming edge
      cur_req = req;
      if (m_phase == 0) begin
        w = pick(cur_req, m_rr);
        if (w >= 0) m_grant(w);
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (ready) begin
        w = pick(cur_req & ~e_gnt, m_rr);
        if (w >= 0) m_grant(w);
        else begin m_phase = 0; m_owner = -1; end
      end
      // Requester behaviour for the next cycle
      n_req = cur_req;
      for (int i = 0; i < NREQ; i++) begin
        if (!cur_req[i]) n_req[i] = ($urandom_range(0, 3) == 0);
        else if (e_ack[i]) n_req[i] = ($urandom_range(0, 3) == 0);
        else if (e_gnt[i]) n_req[i] = ($urandom_range(0, 15) != 0);
      end
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (n_req[i] && (!cur_req[i] || e_ack[i]))
          set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      req    = n_req;
      prdata = $urandom;
`ifdef APB3_WAIT_EN
      pready  = ($urandom_range(0, 2) != 0);
      pslverr = ($urandom_range(0, 3) == 0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
